// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART framing constants and receiver state encoding
// Holds the baud divider and data width used by both uart_send and uart_recv,
// plus the receiver state enumeration.
package uart_pkg;

    // 100 MHz / 9600 baud
    localparam int UART_CLK_DIV   = 10416;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous bit
// Ports:
//   clk  in   sampling clock
//   rst  in   asynchronous active-high reset, both flops load RESET_VAL
//   d    in   asynchronous input
//   q    out  synchronised output, two clk cycles behind d
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_recv.sv
// rtl/uart_recv.sv - UART 8N1 receiver with mid-bit sampling and frame error flag
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   rxd        in   serial line, idle high, asynchronous to clk
//   data       out  last correctly received byte, held until the next good frame
//   valid      out  one-cycle pulse, data is new in the same cycle
//   frame_err  out  one-cycle pulse, stop bit was sampled low
//   busy       out  high whenever the receiver is not idle
module uart_recv
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = UART_CLK_DIV,
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int HALF  = CLK_DIV / 2;
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [15:0]      HALF_LAST = 16'(HALF - 1);
    localparam logic [15:0]      BIT_LAST  = 16'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_t          state;
    logic [15:0]          cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rx_s)
    );

    // busy is updated together with every state transition so it always
    // equals (state != IDLE) without a combinational output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= 16'd0;
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= 16'd0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            // Line went back high before mid start bit: glitch.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= 16'd0;
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= 16'd0;
                        if (rx_s) begin
                            // Returning to IDLE mid stop bit lets a start bit
                            // that follows immediately be caught.
                            data  <= shreg;
                            valid <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                BREAK: begin
                    // A held-low line must go high before a new frame can start.
                    if (rx_s) begin
                        cnt   <= 16'd0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                default: begin
                    cnt   <= 16'd0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_recv.sv
// tb/tb_uart_recv.sv - scoreboard testbench for uart_recv
module tb_uart_recv;

    localparam int DIV      = 16;
    localparam int SLOW_DIV = 1000;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         t0;
        int         lat;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic       rxd_s;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
    logic [7:0] data_s;
    logic       valid_s;
    logic       frame_err_s;
    logic       busy_s;

    int   cyc;
    int   n_chk;
    int   n_err;
    exp_t q0[$];
    exp_t q1[$];
    logic [7:0] model_data [2];

    uart_recv #(.CLK_DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    uart_recv #(.CLK_DIV(SLOW_DIV)) dut_slow (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd_s),
        .data      (data_s),
        .valid     (valid_s),
        .frame_err (frame_err_s),
        .busy      (busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic on_output(input int sel, input logic v, input logic fe, input logic [7:0] d);
        exp_t e;
        if (v || fe) begin
            check("excl", {31'b0, v & fe}, 32'd0);
            if (sel == 0 && q0.size() != 0) begin
                e = q0.pop_front();
            end else if (sel == 1 && q1.size() != 0) begin
                e = q1.pop_front();
            end else begin
                check("unexpected_out", 32'(sel == 0 ? q0.size() : q1.size()), 32'd1);
                return;
            end
            check("kind", {31'b0, fe}, {31'b0, e.err});
            check("data", {24'b0, d}, {24'b0, e.data});
            check("latency", 32'(cyc - e.t0), 32'(e.lat));
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit, input int sel,
                        input int max_cyc, input bit expect_out);
        int   div;
        int   k;
        logic bv;
        exp_t e;
        div = (sel == 0) ? DIV : SLOW_DIV;
        for (int i = 0; i < 10 * div && i < max_cyc; i++) begin
            k = i / div;
            @(negedge clk);
            if (k == 0)      bv = 1'b0;
            else if (k == 9) bv = stop_bit;
            else             bv = b[k-1];
            if (sel == 0) rxd = bv;
            else          rxd_s = bv;
            if (i == 0 && expect_out) begin
                e.err  = !stop_bit;
                e.data = stop_bit ? b : model_data[sel];
                e.t0   = cyc;
                e.lat  = 2 + div / 2 + 9 * div + 1;
                if (stop_bit) model_data[sel] = b;
                if (sel == 0) q0.push_back(e);
                else          q1.push_back(e);
            end
        end
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
        check("drain", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    initial begin
        bit saw_busy;
        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        model_data[0] = 8'h00;
        model_data[1] = 8'h00;
        rst   = 1'b1;
        rxd   = 1'b1;
        rxd_s = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    on_output(0, valid, frame_err, data);
                    on_output(1, valid_s, frame_err_s, data_s);
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_data", {24'b0, data}, 32'h00);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_ferr", {31'b0, frame_err}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_busy_slow", {31'b0, busy_s}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_busy", {31'b0, busy}, 32'd0);

        // single frame
        send(8'hA5, 1'b1, 0, 1_000_000, 1'b1);
        repeat (4) @(negedge clk);
        drain(50);

        // back-to-back, zero idle gap
        send(8'h00, 1'b1, 0, 1_000_000, 1'b1);
        send(8'hFF, 1'b1, 0, 1_000_000, 1'b1);
        drain(50);
        repeat (5) @(negedge clk);

        // short low glitch on idle line
        saw_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rxd = 1'b0;
            if (busy) saw_busy = 1'b1;
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rxd = 1'b1;
            if (busy) saw_busy = 1'b1;
        end
        check("glitch_busy_seen", {31'b0, saw_busy}, 32'd1);
        check("glitch_idle", {31'b0, busy}, 32'd0);
        repeat (20) @(negedge clk);

        // bad stop bit then held-low break
        send(8'h3C, 1'b0, 0, 1_000_000, 1'b1);
        repeat (100) @(negedge clk) rxd = 1'b0;
        drain(10);
        check("break_busy", {31'b0, busy}, 32'd1);
        check("break_data", {24'b0, data}, 32'hFF);
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        check("break_release", {31'b0, busy}, 32'd0);
        repeat (10) @(negedge clk);

        // reset mid-frame
        send(8'h81, 1'b1, 0, 70, 1'b0);
        @(negedge clk);
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        rxd = 1'b1;
        rst = 1'b1;
        model_data[0] = 8'h00;
        @(posedge clk);
        #1;
        check("midrst_data", {24'b0, data}, 32'h00);
        check("midrst_valid", {31'b0, valid}, 32'd0);
        check("midrst_ferr", {31'b0, frame_err}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send(8'h81, 1'b1, 0, 1_000_000, 1'b1);
        drain(50);

        // wider divider: latency scales as 2 + HALF + 9*CLK_DIV + 1
        send(8'h55, 1'b1, 1, 1_000_000, 1'b1);
        drain(2000);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
